// File: rtl/issue_sched_if.sv
`default_nettype none
// ============================================================================
//  Module   : issue_sched_if
//  Brief    : Decode-pair input, writeback completion and dual issue port
//             bundle for the in-order dual-issue scheduler.
//  Revision : 1.0  initial release
// ============================================================================
interface issue_sched_if;
  // decoded pair from the front end (instr 1 is the older one)
  logic        en_flag_i;
  logic        in_ready_o;
  logic [6:0]  PC1_i;
  logic [6:0]  PC2_i;
  logic [6:0]  opcode_1;
  logic [6:0]  opcode_2;
  logic [4:0]  rs1_1;
  logic [4:0]  rs2_1;
  logic [4:0]  rd_1;
  logic [4:0]  rs1_2;
  logic [4:0]  rs2_2;
  logic [4:0]  rd_2;
  logic [31:0] instr_1_;
  logic [31:0] instr_2_;
  logic        flush_i;
  // writeback completions
  logic        wb0_valid_i;
  logic        wb1_valid_i;
  logic [4:0]  wb0_rd_i;
  logic [4:0]  wb1_rd_i;
  // issue ports
  logic        iss0_valid_o;
  logic        iss1_valid_o;
  logic [31:0] iss0_instr_o;
  logic [31:0] iss1_instr_o;
  logic [6:0]  iss0_pc_o;
  logic [6:0]  iss1_pc_o;
  logic [31:0] stall_cnt_o;

  // scheduler side
  modport slave (
    input  en_flag_i, PC1_i, PC2_i, opcode_1, opcode_2,
           rs1_1, rs2_1, rd_1, rs1_2, rs2_2, rd_2,
           instr_1_, instr_2_, flush_i,
           wb0_valid_i, wb1_valid_i, wb0_rd_i, wb1_rd_i,
    output in_ready_o, iss0_valid_o, iss1_valid_o,
           iss0_instr_o, iss1_instr_o, iss0_pc_o, iss1_pc_o, stall_cnt_o
  );

  // front end / environment side
  modport master (
    output en_flag_i, PC1_i, PC2_i, opcode_1, opcode_2,
           rs1_1, rs2_1, rd_1, rs1_2, rs2_2, rd_2,
           instr_1_, instr_2_, flush_i,
           wb0_valid_i, wb1_valid_i, wb0_rd_i, wb1_rd_i,
    input  in_ready_o, iss0_valid_o, iss1_valid_o,
           iss0_instr_o, iss1_instr_o, iss0_pc_o, iss1_pc_o, stall_cnt_o
  );
endinterface
`default_nettype wire

// File: rtl/issue_sched.sv
`default_nettype none
// ============================================================================
//  Module   : issue_sched
//  Brief    : In-order dual-issue scheduler. Buffers one decoded pair, checks
//             a 32-entry busy scoreboard (with writeback bypass), and issues
//             the older instruction on port 0 and, when legal, the younger
//             one alongside it on port 1.
//  Revision : 1.0  initial release
// ============================================================================
module issue_sched (
  input  logic          clk,
  input  logic          rst_n,
  issue_sched_if.slave  bus
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD12 = 2'd1,
    HOLD2  = 2'd2
  } state_t;

  // Register fields are stored already masked by operand class: an unread
  // source or unwritten destination is held as x0, which is always ready
  // and never creates a RAW/WAW hazard.
  typedef struct packed {
    logic [6:0]  pc;
    logic [31:0] instr;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        lsu;
  } slot_t;

  function automatic slot_t decode(input logic [6:0] pc, input logic [6:0] op,
                                   input logic [4:0] rs1, input logic [4:0] rs2,
                                   input logic [4:0] rd, input logic [31:0] instr);
    slot_t s;
    logic  rd_rs1;
    logic  rd_rs2;
    logic  wr_rd;
    rd_rs1  = (op == OP_R) || (op == OP_IMM) || (op == OP_LOAD) || (op == OP_STORE);
    rd_rs2  = (op == OP_R) || (op == OP_STORE);
    wr_rd   = (op == OP_R) || (op == OP_IMM) || (op == OP_LOAD);
    s.pc    = pc;
    s.instr = instr;
    s.rs1   = rd_rs1 ? rs1 : 5'd0;
    s.rs2   = rd_rs2 ? rs2 : 5'd0;
    s.rd    = wr_rd  ? rd  : 5'd0;
    s.lsu   = (op == OP_LOAD) || (op == OP_STORE);
    return s;
  endfunction

  state_t      state_q, state_d;
  slot_t       slot_a_q, slot_a_d;   // older instruction
  slot_t       slot_b_q, slot_b_d;   // younger instruction
  logic [31:0] busy_q, busy_d;
  logic [31:0] stall_q, stall_d;
  logic        iss0_valid_q, iss0_valid_d;
  logic        iss1_valid_q, iss1_valid_d;
  logic [31:0] iss0_instr_q, iss0_instr_d;
  logic [31:0] iss1_instr_q, iss1_instr_d;
  logic [6:0]  iss0_pc_q, iss0_pc_d;
  logic [6:0]  iss1_pc_q, iss1_pc_d;

  logic [31:0] wb_clr;
  logic [31:0] avail;
  logic [31:0] busy_set;
  logic        old_ok, yng_ok, raw_haz, waw_haz, lsu_haz;
  logic        issue_old, issue_dual, issue_yng;
  logic        drain, ready_int, accept;

  // Writeback clear mask; x0 is never tracked, duplicate rd clears once.
  always_comb begin
    wb_clr = '0;
    if (bus.wb0_valid_i) wb_clr[bus.wb0_rd_i] = 1'b1;
    if (bus.wb1_valid_i) wb_clr[bus.wb1_rd_i] = 1'b1;
    wb_clr[0] = 1'b0;
    avail     = ~busy_q | wb_clr;
  end

  // Hazard checks and issue decision for the buffered instructions.
  always_comb begin
    old_ok     = avail[slot_a_q.rs1] && avail[slot_a_q.rs2];
    yng_ok     = avail[slot_b_q.rs1] && avail[slot_b_q.rs2];
    raw_haz    = (slot_a_q.rd != 5'd0) &&
                 ((slot_b_q.rs1 == slot_a_q.rd) || (slot_b_q.rs2 == slot_a_q.rd));
    waw_haz    = (slot_a_q.rd != 5'd0) && (slot_b_q.rd == slot_a_q.rd);
    lsu_haz    = slot_a_q.lsu && slot_b_q.lsu;
    issue_old  = (state_q == HOLD12) && old_ok && !bus.flush_i;
    issue_dual = issue_old && yng_ok && !raw_haz && !waw_haz && !lsu_haz;
    issue_yng  = (state_q == HOLD2) && yng_ok && !bus.flush_i;
    drain      = issue_dual || issue_yng;
    ready_int  = ((state_q == IDLE) || drain) && !bus.flush_i;
    accept     = bus.en_flag_i && ready_int && rst_n;
  end

  assign bus.in_ready_o = ready_int && rst_n;

  // Next state, buffer load, issue port contents, scoreboard and stall count.
  always_comb begin
    state_d      = state_q;
    slot_a_d     = slot_a_q;
    slot_b_d     = slot_b_q;
    stall_d      = stall_q;
    busy_set     = '0;
    iss0_valid_d = 1'b0;
    iss1_valid_d = 1'b0;
    iss0_instr_d = '0;
    iss1_instr_d = '0;
    iss0_pc_d    = '0;
    iss1_pc_d    = '0;

    if (issue_old) begin
      iss0_valid_d          = 1'b1;
      iss0_instr_d          = slot_a_q.instr;
      iss0_pc_d             = slot_a_q.pc;
      busy_set[slot_a_q.rd] = 1'b1;
    end
    if (issue_dual) begin
      iss1_valid_d          = 1'b1;
      iss1_instr_d          = slot_b_q.instr;
      iss1_pc_d             = slot_b_q.pc;
      busy_set[slot_b_q.rd] = 1'b1;
    end
    if (issue_yng) begin
      iss0_valid_d          = 1'b1;
      iss0_instr_d          = slot_b_q.instr;
      iss0_pc_d             = slot_b_q.pc;
      busy_set[slot_b_q.rd] = 1'b1;
    end
    busy_set[0] = 1'b0;

    if (bus.flush_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        HOLD12: begin
          if (issue_dual)     state_d = IDLE;
          else if (issue_old) state_d = HOLD2;
        end
        HOLD2: begin
          if (issue_yng) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
      if ((state_q != IDLE) && !issue_old && !issue_yng && (stall_q != 32'hFFFF_FFFF))
        stall_d = stall_q + 32'd1;
    end

    // A pair accepted on a draining cycle refills the buffer directly.
    if (accept) begin
      state_d  = HOLD12;
      slot_a_d = decode(bus.PC1_i, bus.opcode_1, bus.rs1_1, bus.rs2_1,
                        bus.rd_1, bus.instr_1_);
      slot_b_d = decode(bus.PC2_i, bus.opcode_2, bus.rs1_2, bus.rs2_2,
                        bus.rd_2, bus.instr_2_);
    end

    // Set wins over a same-cycle writeback clear of the same register.
    busy_d    = (busy_q & ~wb_clr) | busy_set;
    busy_d[0] = 1'b0;
  end

  // State, buffer, scoreboard and registered issue outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      slot_a_q     <= '0;
      slot_b_q     <= '0;
      busy_q       <= '0;
      stall_q      <= '0;
      iss0_valid_q <= 1'b0;
      iss1_valid_q <= 1'b0;
      iss0_instr_q <= '0;
      iss1_instr_q <= '0;
      iss0_pc_q    <= '0;
      iss1_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      slot_a_q     <= slot_a_d;
      slot_b_q     <= slot_b_d;
      busy_q       <= busy_d;
      stall_q      <= stall_d;
      iss0_valid_q <= iss0_valid_d;
      iss1_valid_q <= iss1_valid_d;
      iss0_instr_q <= iss0_instr_d;
      iss1_instr_q <= iss1_instr_d;
      iss0_pc_q    <= iss0_pc_d;
      iss1_pc_q    <= iss1_pc_d;
    end
  end

  assign bus.iss0_valid_o = iss0_valid_q;
  assign bus.iss1_valid_o = iss1_valid_q;
  assign bus.iss0_instr_o = iss0_instr_q;
  assign bus.iss1_instr_o = iss1_instr_q;
  assign bus.iss0_pc_o    = iss0_pc_q;
  assign bus.iss1_pc_o    = iss1_pc_q;
  assign bus.stall_cnt_o  = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_issue_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_issue_sched
//  Brief    : Directed self-checking bench for issue_sched.
//  Revision : 1.0  initial release
// ============================================================================
module tb_issue_sched;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  issue_sched_if bus();

  issue_sched dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.en_flag_i   = 1'b0;
    bus.flush_i     = 1'b0;
    bus.wb0_valid_i = 1'b0;
    bus.wb1_valid_i = 1'b0;
    bus.wb0_rd_i    = 5'd0;
    bus.wb1_rd_i    = 5'd0;
  endtask

  task automatic set_pair(input logic [6:0] p1, input logic [6:0] o1,
                          input logic [4:0] a1, input logic [4:0] b1,
                          input logic [4:0] d1, input logic [31:0] i1,
                          input logic [6:0] p2, input logic [6:0] o2,
                          input logic [4:0] a2, input logic [4:0] b2,
                          input logic [4:0] d2, input logic [31:0] i2);
    bus.PC1_i = p1; bus.opcode_1 = o1; bus.rs1_1 = a1; bus.rs2_1 = b1;
    bus.rd_1  = d1; bus.instr_1_ = i1;
    bus.PC2_i = p2; bus.opcode_2 = o2; bus.rs1_2 = a2; bus.rs2_2 = b2;
    bus.rd_2  = d2; bus.instr_2_ = i2;
    bus.en_flag_i = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    set_pair(7'h0, OP_R, 5'd0, 5'd0, 5'd0, 32'h0, 7'h0, OP_R, 5'd0, 5'd0, 5'd0, 32'h0);
    bus.en_flag_i = 1'b0;
    rst_n = 1'b0;
    step(); step();
    checks++;
    if (bus.iss0_valid_o !== 1'b0 || bus.iss1_valid_o !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b/%b want 0/0", bus.iss0_valid_o, bus.iss1_valid_o);
    end
    checks++;
    if (bus.in_ready_o !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready_o);
    end
    checks++;
    if (bus.stall_cnt_o !== 32'd0 || dut.busy_q !== 32'd0) begin
      errors++; $display("FAIL reset_state: stall=%0d busy=%h want 0/0", bus.stall_cnt_o, dut.busy_q);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.in_ready_o !== 1'b1) begin
      errors++; $display("FAIL release_in_ready: got %b want 1", bus.in_ready_o);
    end
  endtask

  task automatic test_dual_issue();
    set_pair(7'h10, OP_R, 5'd2, 5'd3, 5'd1, 32'hA000_0001,
             7'h11, OP_IMM, 5'd4, 5'd9, 5'd2, 32'hA000_0002);
    step();
    bus.en_flag_i = 1'b0;
    #1;
    checks++;
    if (bus.iss0_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1) begin
      errors++; $display("FAIL dual_hold_cycle: valid=%b ready=%b want 0/1", bus.iss0_valid_o, bus.in_ready_o);
    end
    step();
    checks++;
    if (bus.iss0_valid_o !== 1'b1 || bus.iss0_pc_o !== 7'h10 || bus.iss0_instr_o !== 32'hA000_0001) begin
      errors++; $display("FAIL dual_port0: v=%b pc=%h instr=%h want 1/10/a0000001",
                         bus.iss0_valid_o, bus.iss0_pc_o, bus.iss0_instr_o);
    end
    checks++;
    if (bus.iss1_valid_o !== 1'b1 || bus.iss1_pc_o !== 7'h11 || bus.iss1_instr_o !== 32'hA000_0002) begin
      errors++; $display("FAIL dual_port1: v=%b pc=%h instr=%h want 1/11/a0000002",
                         bus.iss1_valid_o, bus.iss1_pc_o, bus.iss1_instr_o);
    end
    checks++;
    if (dut.busy_q[1] !== 1'b1 || dut.busy_q[2] !== 1'b1 || dut.busy_q[4] !== 1'b0) begin
      errors++; $display("FAIL dual_busy: busy=%h want bits 1,2 set", dut.busy_q);
    end
    bus.wb0_valid_i = 1'b1; bus.wb0_rd_i = 5'd1;
    bus.wb1_valid_i = 1'b1; bus.wb1_rd_i = 5'd2;
    step();
    idle_inputs();
    checks++;
    if (bus.iss0_valid_o !== 1'b0 || bus.iss1_valid_o !== 1'b0 || dut.busy_q !== 32'd0) begin
      errors++; $display("FAIL dual_after: v=%b/%b busy=%h want 0/0/0",
                         bus.iss0_valid_o, bus.iss1_valid_o, dut.busy_q);
    end
  endtask

  task automatic test_raw_split();
    set_pair(7'h20, OP_R, 5'd5, 5'd6, 5'd3, 32'hB000_0001,
             7'h21, OP_R, 5'd3, 5'd5, 5'd4, 32'hB000_0002);
    step();
    bus.en_flag_i = 1'b0;
    #1;
    checks++;
    if (bus.in_ready_o !== 1'b0) begin
      errors++; $display("FAIL raw_ready_hold12: got %b want 0", bus.in_ready_o);
    end
    step();
    checks++;
    if (bus.iss0_valid_o !== 1'b1 || bus.iss0_pc_o !== 7'h20 || bus.iss1_valid_o !== 1'b0) begin
      errors++; $display("FAIL raw_older: v0=%b pc0=%h v1=%b want 1/20/0",
                         bus.iss0_valid_o, bus.iss0_pc_o, bus.iss1_valid_o);
    end
    bus.wb0_valid_i = 1'b1; bus.wb0_rd_i = 5'd3;
    #1;
    checks++;
    if (bus.in_ready_o !== 1'b1) begin
      errors++; $display("FAIL raw_ready_drain: got %b want 1", bus.in_ready_o);
    end
    step();
    idle_inputs();
    checks++;
    if (bus.iss0_valid_o !== 1'b1 || bus.iss0_pc_o !== 7'h21 || bus.iss1_valid_o !== 1'b0) begin
      errors++; $display("FAIL raw_younger: v0=%b pc0=%h v1=%b want 1/21/0",
                         bus.iss0_valid_o, bus.iss0_pc_o, bus.iss1_valid_o);
    end
    checks++;
    if (bus.stall_cnt_o !== 32'd0 || dut.busy_q[3] !== 1'b0 || dut.busy_q[4] !== 1'b1) begin
      errors++; $display("FAIL raw_state: stall=%0d busy=%h want 0, b3=0 b4=1", bus.stall_cnt_o, dut.busy_q);
    end
    bus.wb0_valid_i = 1'b1; bus.wb0_rd_i = 5'd4;
    step();
    idle_inputs();
  endtask

  task automatic test_lsu_split();
    set_pair(7'h30, OP_LOAD,  5'd10, 5'd0, 5'd6, 32'hC000_0001,
             7'h31, OP_STORE, 5'd11, 5'd7, 5'd0, 32'hC000_0002);
    step();
    bus.en_flag_i = 1'b0;
    step();
    checks++;
    if (bus.iss0_valid_o !== 1'b1 || bus.iss0_pc_o !== 7'h30 || bus.iss1_valid_o !== 1'b0) begin
      errors++; $display("FAIL lsu_first: v0=%b pc0=%h v1=%b want 1/30/0",
                         bus.iss0_valid_o, bus.iss0_pc_o, bus.iss1_valid_o);
    end
    step();
    checks++;
    if (bus.iss0_valid_o !== 1'b1 || bus.iss0_pc_o !== 7'h31 || bus.iss0_instr_o !== 32'hC000_0002 ||
        bus.iss1_valid_o !== 1'b0) begin
      errors++; $display("FAIL lsu_second: v0=%b pc0=%h instr=%h v1=%b want 1/31/c0000002/0",
                         bus.iss0_valid_o, bus.iss0_pc_o, bus.iss0_instr_o, bus.iss1_valid_o);
    end
    checks++;
    if (bus.stall_cnt_o !== 32'd0 || dut.busy_q !== 32'h0000_0040) begin
      errors++; $display("FAIL lsu_state: stall=%0d busy=%h want 0/00000040", bus.stall_cnt_o, dut.busy_q);
    end
    bus.wb0_valid_i = 1'b1; bus.wb0_rd_i = 5'd6;
    bus.wb1_valid_i = 1'b1; bus.wb1_rd_i = 5'd6;
    step();
    idle_inputs();
    checks++;
    if (dut.busy_q !== 32'd0) begin
      errors++; $display("FAIL lsu_wb_clear: busy=%h want 0", dut.busy_q);
    end
  endtask

  task automatic test_stall_bypass();
    // ADDI x8 with an opcode that writes nothing (its rd field is ignored)
    set_pair(7'h40, OP_IMM, 5'd0, 5'd0, 5'd8, 32'hD000_0001,
             7'h41, OP_SYS, 5'd8, 5'd8, 5'd8, 32'hD000_0002);
    step();
    bus.en_flag_i = 1'b0;
    step();
    checks++;
    if (bus.iss0_valid_o !== 1'b1 || bus.iss1_valid_o !== 1'b1 || dut.busy_q !== 32'h0000_0100) begin
      errors++; $display("FAIL stall_setup: v=%b/%b busy=%h want 1/1/00000100",
                         bus.iss0_valid_o, bus.iss1_valid_o, dut.busy_q);
    end
    set_pair(7'h42, OP_R,   5'd8, 5'd0, 5'd9,  32'hD000_0003,
             7'h43, OP_IMM, 5'd0, 5'd0, 5'd10, 32'hD000_0004);
    step();
    bus.en_flag_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.iss0_valid_o !== 1'b0) begin
        errors++; $display("FAIL stall_hold_%0d: iss0_valid=%b want 0", i, bus.iss0_valid_o);
      end
    end
    bus.wb0_valid_i = 1'b1; bus.wb0_rd_i = 5'd8;
    #1;
    checks++;
    if (bus.in_ready_o !== 1'b1) begin
      errors++; $display("FAIL stall_bypass_ready: got %b want 1", bus.in_ready_o);
    end
    step();
    idle_inputs();
    checks++;
    if (bus.iss0_valid_o !== 1'b1 || bus.iss0_pc_o !== 7'h42 ||
        bus.iss1_valid_o !== 1'b1 || bus.iss1_pc_o !== 7'h43) begin
      errors++; $display("FAIL stall_issue: v0=%b pc0=%h v1=%b pc1=%h want 1/42/1/43",
                         bus.iss0_valid_o, bus.iss0_pc_o, bus.iss1_valid_o, bus.iss1_pc_o);
    end
    checks++;
    if (bus.stall_cnt_o !== 32'd3 || dut.busy_q !== 32'h0000_0600) begin
      errors++; $display("FAIL stall_count: stall=%0d busy=%h want 3/00000600", bus.stall_cnt_o, dut.busy_q);
    end
    bus.wb0_valid_i = 1'b1; bus.wb0_rd_i = 5'd9;
    bus.wb1_valid_i = 1'b1; bus.wb1_rd_i = 5'd10;
    step();
    idle_inputs();
  endtask

  task automatic test_flush();
    set_pair(7'h50, OP_R, 5'd0,  5'd0, 5'd12, 32'hE000_0001,
             7'h51, OP_R, 5'd12, 5'd0, 5'd13, 32'hE000_0002);
    step();
    bus.en_flag_i = 1'b0;
    step();
    checks++;
    if (bus.iss0_valid_o !== 1'b1 || bus.iss0_pc_o !== 7'h50 || bus.iss1_valid_o !== 1'b0) begin
      errors++; $display("FAIL flush_older: v0=%b pc0=%h v1=%b want 1/50/0",
                         bus.iss0_valid_o, bus.iss0_pc_o, bus.iss1_valid_o);
    end
    set_pair(7'h52, OP_IMM, 5'd0, 5'd0, 5'd14, 32'hE000_0003,
             7'h53, OP_IMM, 5'd0, 5'd0, 5'd15, 32'hE000_0004);
    bus.flush_i = 1'b1;
    #1;
    checks++;
    if (bus.in_ready_o !== 1'b0) begin
      errors++; $display("FAIL flush_ready: got %b want 0", bus.in_ready_o);
    end
    step();
    idle_inputs();
    #1;
    checks++;
    if (bus.iss0_valid_o !== 1'b0 || bus.iss1_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1) begin
      errors++; $display("FAIL flush_after: v=%b/%b ready=%b want 0/0/1",
                         bus.iss0_valid_o, bus.iss1_valid_o, bus.in_ready_o);
    end
    step();
    checks++;
    if (bus.iss0_valid_o !== 1'b0 || bus.stall_cnt_o !== 32'd3 || dut.busy_q !== 32'h0000_1000) begin
      errors++; $display("FAIL flush_dropped: v0=%b stall=%0d busy=%h want 0/3/00001000",
                         bus.iss0_valid_o, bus.stall_cnt_o, dut.busy_q);
    end
  endtask

  task automatic test_reset_in_hold();
    // x12 is still busy, so this pair sits in the buffer
    set_pair(7'h60, OP_R,   5'd12, 5'd0, 5'd14, 32'hF000_0001,
             7'h61, OP_IMM, 5'd0,  5'd0, 5'd15, 32'hF000_0002);
    step();
    bus.en_flag_i = 1'b0;
    step();
    checks++;
    if (bus.iss0_valid_o !== 1'b0 || bus.stall_cnt_o !== 32'd4 || bus.in_ready_o !== 1'b0) begin
      errors++; $display("FAIL hold_before_reset: v0=%b stall=%0d ready=%b want 0/4/0",
                         bus.iss0_valid_o, bus.stall_cnt_o, bus.in_ready_o);
    end
    rst_n = 1'b0;
    step();
    checks++;
    if (bus.iss0_valid_o !== 1'b0 || bus.iss1_valid_o !== 1'b0 || bus.iss0_pc_o !== 7'd0 ||
        bus.iss0_instr_o !== 32'd0 || bus.stall_cnt_o !== 32'd0 || dut.busy_q !== 32'd0 ||
        bus.in_ready_o !== 1'b0) begin
      errors++; $display("FAIL mid_reset: v=%b/%b pc=%h stall=%0d busy=%h ready=%b want all 0",
                         bus.iss0_valid_o, bus.iss1_valid_o, bus.iss0_pc_o, bus.stall_cnt_o,
                         dut.busy_q, bus.in_ready_o);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.in_ready_o !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got %b want 1", bus.in_ready_o);
    end
    step();
    checks++;
    if (bus.iss0_valid_o !== 1'b0 || bus.stall_cnt_o !== 32'd0) begin
      errors++; $display("FAIL buffer_discarded: v0=%b stall=%0d want 0/0", bus.iss0_valid_o, bus.stall_cnt_o);
    end
  endtask

  initial begin
    test_reset();
    test_dual_issue();
    test_raw_split();
    test_lsu_split();
    test_stall_bypass();
    test_flush();
    test_reset_in_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/issue_sched.md
ISSUE_SCHED -- requirements
Module: issue_sched

Interface
REQ-001 Clocking SHALL be one clock, clk; reset SHALL be rst_n, synchronous, active-low.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  synchronous active-low reset.
REQ-004 en_flag_i  in  1  decoded pair valid; instr 1 is older.
REQ-005 in_ready_o  out  1  pair accepted on edge when en_flag_i && in_ready_o.
REQ-006 PC1_i / PC2_i  in  7  pair PCs.
REQ-007 opcode_1 / opcode_2  in  7  decoded opcodes.
REQ-008 rs1_1, rs2_1, rd_1 / rs1_2, rs2_2, rd_2  in  5  register fields.
REQ-009 instr_1_ / instr_2_  in  32  raw instructions.
REQ-010 flush_i  in  1  discard held instructions.
REQ-011 wb0_valid_i, wb1_valid_i  in  1; wb0_rd_i, wb1_rd_i  in  5  writeback completions.
REQ-012 iss0_valid_o, iss1_valid_o  out  1; iss0_instr_o, iss1_instr_o  out  32; iss0_pc_o, iss1_pc_o  out  7  issue ports, all registered.
REQ-013 stall_cnt_o  out  32  count of held-no-issue cycles.

Function
REQ-014 Operand classes SHALL be: 0110011 reads rs1,rs2, writes rd; 0010011, 0000011 read rs1, write rd; 0100011 reads rs1,rs2, no rd; any other opcode reads nothing, writes nothing, and SHALL still issue.
REQ-015 A 32-bit scoreboard SHALL hold busy[r]; busy[0] SHALL always read 0.
REQ-016 Source ready SHALL be: not busy[r], or cleared by a wb port in the same cycle (bypass).
REQ-017 States SHALL be IDLE (buffer empty), HOLD12 (both held), HOLD2 (only younger held).
REQ-018 IDLE: accepted pair captured -> HOLD12; no issue that cycle.
REQ-019 HOLD12: older issues iff its sources are ready; younger issues with it iff older issues, younger sources ready, younger does not read nonzero rd of older (RAW), younger rd != nonzero older rd (WAW), and not both opcodes in {0000011,0100011} (single LSU).
REQ-020 HOLD12 transitions: both issue -> IDLE; only older -> HOLD2; none -> HOLD12.
REQ-021 HOLD2: younger issues iff sources ready -> IDLE; else stay.
REQ-022 in_ready_o SHALL be combinational: 1 in IDLE, or when the buffer fully drains this cycle; a pair accepted on a draining cycle SHALL load the buffer -> HOLD12.
REQ-023 Oldest issued instruction SHALL always drive port 0; port 1 only carries the younger of a dual issue.
REQ-024 Issue decided in cycle N SHALL appear on iss*_o in cycle N+1 (valid one cycle only); minimum accept-to-issue latency is 2 cycles.
REQ-025 On issue, busy[rd] SHALL be set on the same edge the iss register loads; same-cycle set and wb clear of one register: set wins.
REQ-026 wb with rd=0 SHALL be ignored; two wb ports to the same rd SHALL clear once.
REQ-027 flush_i SHALL force IDLE, suppress issue that cycle, force in_ready_o=0, drop any incoming pair; scoreboard unchanged.
REQ-028 stall_cnt_o SHALL increment in each HOLD12/HOLD2 cycle with no issue and no flush; saturate at 0xFFFFFFFF.

Reset
REQ-029 On rst_n=0 at a clk edge: state IDLE, busy all 0, all iss*_o 0, stall_cnt_o 0; reset mid-hold SHALL discard buffer.
REQ-030 During reset in_ready_o SHALL be 0; 1 from first cycle after release.

Verification
REQ-031 Independent pair ADD x1 / ADDI x2, scoreboard clear -> both issue 2 cycles after accept, port0 PC1, port1 PC2, busy[1], busy[2] set.
REQ-032 Pair ADD x3,.. / XOR x4,x3,x5 -> older issues alone, younger issues next cycle on port 0; stall_cnt_o unchanged.
REQ-033 LW x6 / SW x7 pair -> single-LSU rule splits issue over two cycles.
REQ-034 busy[8] set, pair reads x8; hold 3 cycles then wb0 rd=8 -> issue that cycle's decision, stall_cnt_o +3.
REQ-035 flush_i asserted in HOLD2 with simultaneous en_flag_i -> no issue, pair dropped, IDLE, in_ready_o=1 next cycle.
REQ-036 rst_n low in HOLD12 -> all outputs 0 next cycle, busy cleared.
